// File: rtl/grf_dump_if.sv
// GRF read port plus the indexed dump word stream, bundled for grf_dump.
// master = the dumper, slave = GRF / consumer side.
interface grf_dump_if #(
    parameter int AW = 5
);
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_idx;
    logic [31:0]   dump_data;

    modport master (
        output rd_addr,
        input  rd_data,
        output dump_valid,
        input  dump_ready,
        output dump_idx,
        output dump_data
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  dump_valid,
        output dump_ready,
        input  dump_idx,
        input  dump_data
    );
endinterface

// File: rtl/grf_dump.sv
// Walks GRF indices 0..NUM_REGS-1, streams (idx, value) words and a running checksum.
// Latency: first word one cycle after the scan starts; two cycles per word at best.
// Backpressure: a word holds stable in HOLD for as long as dump_ready stays low.
module grf_dump #(
    parameter int NUM_REGS  = 32,
    parameter int AW        = 5,
    parameter int SKIP_ZERO = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    grf_dump_if.master      bus,
    output logic            busy,
    output logic            done,
    output logic [31:0]     checksum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam bit            SKIP     = (SKIP_ZERO != 0);

    state_t        state;
    logic [AW-1:0] idx;
    logic          last;
    logic          skip_word;

    assign last      = (idx == LAST_IDX);
    assign skip_word = SKIP && (bus.rd_data == 32'd0);

    // The index is only meaningful to the GRF while scanning; park at 0 otherwise.
    assign bus.rd_addr = (state == S_READ || state == S_HOLD) ? idx : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            idx            <= '0;
            checksum       <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            bus.dump_valid <= 1'b0;
            bus.dump_idx   <= '0;
            bus.dump_data  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        idx      <= '0;
                        checksum <= 32'd0;
                        busy     <= 1'b1;
                        state    <= S_READ;
                    end
                end

                S_READ: begin
                    // Skipped words still contribute to the checksum.
                    checksum <= checksum + bus.rd_data;
                    if (skip_word) begin
                        if (last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end else begin
                        bus.dump_data  <= bus.rd_data;
                        bus.dump_idx   <= idx;
                        bus.dump_valid <= 1'b1;
                        state          <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (bus.dump_ready) begin
                        bus.dump_valid <= 1'b0;
                        if (last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + IDX_ONE;
                            state <= S_READ;
                        end
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
